// File: rtl/cpu_bus_pkg.sv
// Shared types and defaults for the data-memory arbiter: FSM states, command
// layout and the two-way round-robin pick rule.
package cpu_bus_pkg;

   localparam int ADDR_W_DEF  = 32;
   localparam int DATA_W_DEF  = 32;
   localparam int BE_W_DEF    = DATA_W_DEF / 8;
   localparam int MEM_LAT_DEF = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   typedef struct packed {
      logic                  we;
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] wdata;
      logic [BE_W_DEF-1:0]   be;
   } cmd_t;

   // A lone requester always wins; with both requesting, the pointer decides.
   function automatic logic rr_pick(input logic [1:0] req, input logic rr);
      logic win;
      case (req)
         2'b01:   win = 1'b0;
         2'b10:   win = 1'b1;
         2'b11:   win = rr;
         default: win = 1'b0;
      endcase
      return win;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker. The pointer moves to the loser after every grant.
module rr_arbiter2
   import cpu_bus_pkg::*;
(
   input  logic       clock_i,
   input  logic       reset_ni,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt,
   output logic       winner
);

   logic rr_r;
   logic win_s;
   logic take_s;

   assign win_s  = rr_pick(req, rr_r);
   assign take_s = advance & (req != 2'b00);
   assign winner = win_s;
   assign gnt    = take_s ? (win_s ? 2'b10 : 2'b01) : 2'b00;

   // Pointer update on each accepted grant.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         rr_r <= 1'b0;
      end else if (take_s) begin
         rr_r <= ~win_s;
      end else begin
         rr_r <= rr_r;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the LSU (port 0) and a debug/DMA
// master (port 1): one access in flight, round-robin grant, fixed latency.
module dmem_arbiter
   import cpu_bus_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int MEM_LAT = MEM_LAT_DEF
) (
   input  logic                clock_i,
   input  logic                reset_ni,
   input  logic                m0_req_i,
   input  logic                m0_we_i,
   input  logic [ADDR_W-1:0]   m0_addr_i,
   input  logic [DATA_W-1:0]   m0_wdata_i,
   input  logic [DATA_W/8-1:0] m0_be_i,
   output logic                m0_gnt_o,
   output logic                m0_rvalid_o,
   output logic [DATA_W-1:0]   m0_rdata_o,
   input  logic                m1_req_i,
   input  logic                m1_we_i,
   input  logic [ADDR_W-1:0]   m1_addr_i,
   input  logic [DATA_W-1:0]   m1_wdata_i,
   input  logic [DATA_W/8-1:0] m1_be_i,
   output logic                m1_gnt_o,
   output logic                m1_rvalid_o,
   output logic [DATA_W-1:0]   m1_rdata_o,
   output logic                mem_req_o,
   output logic                mem_we_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [DATA_W-1:0]   mem_wdata_o,
   output logic [DATA_W/8-1:0] mem_be_o,
   input  logic [DATA_W-1:0]   mem_rdata_i,
   output logic                busy_o
);

   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

   state_e              state_r;
   state_e              state_nxt_s;
   logic [CNT_W-1:0]    cnt_r;
   logic                winner_r;
   logic                we_r;
   logic [ADDR_W-1:0]   addr_r;
   logic [DATA_W-1:0]   wdata_r;
   logic [BE_W-1:0]     be_r;
   logic [DATA_W-1:0]   rdata0_r;
   logic [DATA_W-1:0]   rdata1_r;
   logic                rvalid0_r;
   logic                rvalid1_r;
   logic                mem_req_r;
   logic                busy_r;
   logic                advance_s;
   logic                capture_s;
   logic [1:0]          arb_gnt_s;
   logic                arb_win_s;

   // Grants only exist in IDLE, and are forced low while reset is asserted.
   assign advance_s = (state_r == ST_IDLE) & reset_ni;
   assign capture_s = (state_r == ST_WAIT) && (cnt_r <= CNT_W'(1));

   rr_arbiter2 u_rr (
      .clock_i  (clock_i),
      .reset_ni (reset_ni),
      .req      ({m1_req_i, m0_req_i}),
      .advance  (advance_s),
      .gnt      (arb_gnt_s),
      .winner   (arb_win_s)
   );

   // Access sequencing: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (arb_gnt_s != 2'b00) state_nxt_s = ST_ISSUE;
            else                    state_nxt_s = ST_IDLE;
         end
         ST_ISSUE: state_nxt_s = ST_WAIT;
         ST_WAIT: begin
            if (capture_s) state_nxt_s = ST_RESP;
            else           state_nxt_s = ST_WAIT;
         end
         ST_RESP: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State, latched command, latency counter and registered outputs.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_r   <= ST_IDLE;
         cnt_r     <= {CNT_W{1'b0}};
         winner_r  <= 1'b0;
         we_r      <= 1'b0;
         addr_r    <= {ADDR_W{1'b0}};
         wdata_r   <= {DATA_W{1'b0}};
         be_r      <= {BE_W{1'b0}};
         rdata0_r  <= {DATA_W{1'b0}};
         rdata1_r  <= {DATA_W{1'b0}};
         rvalid0_r <= 1'b0;
         rvalid1_r <= 1'b0;
         mem_req_r <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         busy_r    <= (state_nxt_s != ST_IDLE);
         mem_req_r <= (state_nxt_s == ST_ISSUE);
         rvalid0_r <= (state_nxt_s == ST_RESP) & ~winner_r;
         rvalid1_r <= (state_nxt_s == ST_RESP) & winner_r;

         if (arb_gnt_s != 2'b00) begin
            winner_r <= arb_win_s;
            we_r     <= arb_win_s ? m1_we_i    : m0_we_i;
            addr_r   <= arb_win_s ? m1_addr_i  : m0_addr_i;
            wdata_r  <= arb_win_s ? m1_wdata_i : m0_wdata_i;
            be_r     <= arb_win_s ? m1_be_i    : m0_be_i;
         end

         if (state_r == ST_ISSUE) begin
            cnt_r <= CNT_W'(MEM_LAT);
         end else if (state_r == ST_WAIT) begin
            cnt_r <= cnt_r - CNT_W'(1);
         end else begin
            cnt_r <= cnt_r;
         end

         // Writes complete with zero data so the requester never sees stale reads.
         if (capture_s) begin
            if (winner_r) rdata1_r <= we_r ? {DATA_W{1'b0}} : mem_rdata_i;
            else          rdata0_r <= we_r ? {DATA_W{1'b0}} : mem_rdata_i;
         end
      end
   end

   assign m0_gnt_o    = arb_gnt_s[0];
   assign m1_gnt_o    = arb_gnt_s[1];
   assign m0_rvalid_o = rvalid0_r;
   assign m1_rvalid_o = rvalid1_r;
   assign m0_rdata_o  = rdata0_r;
   assign m1_rdata_o  = rdata1_r;
   assign mem_req_o   = mem_req_r;
   assign mem_we_o    = we_r;
   assign mem_addr_o  = addr_r;
   assign mem_wdata_o = wdata_r;
   assign mem_be_o    = be_r;
   assign busy_o      = busy_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random
// two-master traffic, compared cycle by cycle against a transaction-level model.
module tb_dmem_arbiter;

   localparam int LAT = 2;

   logic        clock_i = 1'b0;
   logic        reset_ni;
   logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
   logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
   logic [3:0]  m0_be_i, m1_be_i;
   logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
   logic [31:0] m0_rdata_o, m1_rdata_o;
   logic        mem_req_o, mem_we_o, busy_o;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic [3:0]  mem_be_o;

   always #5 clock_i = ~clock_i;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
      .clock_i(clock_i), .reset_ni(reset_ni),
      .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
      .m0_wdata_i(m0_wdata_i), .m0_be_i(m0_be_i), .m0_gnt_o(m0_gnt_o),
      .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
      .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
      .m1_wdata_i(m1_wdata_i), .m1_be_i(m1_be_i), .m1_gnt_o(m1_gnt_o),
      .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i),
      .busy_o(busy_o)
   );

   // Requester-side variables (one slot per port).
   logic        r_req [2];
   logic        r_we [2];
   logic [31:0] r_addr [2];
   logic [31:0] r_wdata [2];
   logic [3:0]  r_be [2];
   int          hold_cnt [2];
   bit          granted [2];
   bit          rnd_mode;

   assign m0_req_i = r_req[0];   assign m1_req_i = r_req[1];
   assign m0_we_i = r_we[0];     assign m1_we_i = r_we[1];
   assign m0_addr_i = r_addr[0]; assign m1_addr_i = r_addr[1];
   assign m0_wdata_i = r_wdata[0]; assign m1_wdata_i = r_wdata[1];
   assign m0_be_i = r_be[0];     assign m1_be_i = r_be[1];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Memory seen by the DUT, and the model's own shadow of what it should hold.
   logic [31:0] mem [logic [31:0]];
   logic [31:0] shadow [logic [31:0]];

   function automatic logic [31:0] rd(input bit sh, input logic [31:0] a);
      if (sh) begin
         if (shadow.exists(a)) return shadow[a];
      end else begin
         if (mem.exists(a)) return mem[a];
      end
      return {a[15:0], 16'hC0DE};
   endfunction

   task automatic wr(input bit sh, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      logic [31:0] v;
      v = rd(sh, a);
      for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = d[8*b +: 8];
      if (sh) shadow[a] = v; else mem[a] = v;
   endtask

   // Memory responder: read data is valid only in the cycle LAT after the strobe.
   int          pend;
   logic [31:0] pend_addr;
   logic        pend_we;

   task automatic mem_respond();
      mem_rdata_i = $urandom;
      if (!reset_ni) begin
         pend = 0;
      end else if (mem_req_o) begin
         pend = LAT; pend_addr = mem_addr_o; pend_we = mem_we_o;
         if (mem_we_o) wr(1'b0, mem_addr_o, mem_wdata_o, mem_be_o);
      end else if (pend > 0) begin
         pend--;
         if (pend == 0 && !pend_we) mem_rdata_i = rd(1'b0, pend_addr);
      end
   endtask

   // Transaction-level reference model.
   bit          m_active, m_win, m_rr, m_we;
   int          m_age;
   logic [31:0] m_addr, m_wdata, m_data;
   logic [3:0]  m_be;
   logic        e_we;
   logic [31:0] e_addr, e_wdata;
   logic [3:0]  e_be;
   logic [31:0] e_rdata [2];

   task automatic eval_cycle();
      logic [1:0] eg, erv;
      logic ereq, ebusy;
      eg = 2'b00; erv = 2'b00; ereq = 1'b0; ebusy = 1'b0;
      granted[0] = 1'b0; granted[1] = 1'b0;
      if (!reset_ni) begin
         m_active = 1'b0; m_rr = 1'b0;
         e_we = 1'b0; e_addr = 32'd0; e_wdata = 32'd0; e_be = 4'd0;
         e_rdata[0] = 32'd0; e_rdata[1] = 32'd0;
      end else if (!m_active) begin
         if (r_req[0] || r_req[1]) begin
            m_win = (r_req[0] && r_req[1]) ? m_rr : r_req[1];
            m_rr = !m_win;
            m_active = 1'b1; m_age = 0;
            eg[m_win] = 1'b1; granted[m_win] = 1'b1;
            m_we = r_we[m_win]; m_addr = r_addr[m_win];
            m_wdata = r_wdata[m_win]; m_be = r_be[m_win];
         end
      end else begin
         m_age++;
         ebusy = 1'b1;
         if (m_age == 1) begin
            ereq = 1'b1;
            e_we = m_we; e_addr = m_addr; e_wdata = m_wdata; e_be = m_be;
            if (m_we) begin
               wr(1'b1, m_addr, m_wdata, m_be);
               m_data = 32'd0;
            end else begin
               m_data = rd(1'b1, m_addr);
            end
         end
         if (m_age == LAT + 2) begin
            erv[m_win] = 1'b1;
            e_rdata[m_win] = m_data;
            m_active = 1'b0;
         end
      end
      check_val("m0_gnt", 64'(m0_gnt_o), 64'(eg[0]));
      check_val("m1_gnt", 64'(m1_gnt_o), 64'(eg[1]));
      check_val("m0_rvalid", 64'(m0_rvalid_o), 64'(erv[0]));
      check_val("m1_rvalid", 64'(m1_rvalid_o), 64'(erv[1]));
      check_val("m0_rdata", 64'(m0_rdata_o), 64'(e_rdata[0]));
      check_val("m1_rdata", 64'(m1_rdata_o), 64'(e_rdata[1]));
      check_val("mem_req", 64'(mem_req_o), 64'(ereq));
      check_val("busy", 64'(busy_o), 64'(ebusy));
      check_val("mem_we", 64'(mem_we_o), 64'(e_we));
      check_val("mem_addr", 64'(mem_addr_o), 64'(e_addr));
      check_val("mem_wdata", 64'(mem_wdata_o), 64'(e_wdata));
      check_val("mem_be", 64'(mem_be_o), 64'(e_be));
   endtask

   task automatic set_req(input int p, input logic we, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be, input int hold);
      r_req[p] = 1'b1; r_we[p] = we; r_addr[p] = a; r_wdata[p] = d; r_be[p] = be;
      hold_cnt[p] = hold;
   endtask

   task automatic update_requesters();
      for (int p = 0; p < 2; p++) begin
         if (granted[p]) begin
            if (hold_cnt[p] > 0) begin
               hold_cnt[p]--;
               r_addr[p] = r_addr[p] + 32'd4;
            end else begin
               r_req[p] = 1'b0;
            end
         end
         if (rnd_mode) begin
            if (r_req[p] && !granted[p]) begin
               if ($urandom_range(0, 15) == 0) r_req[p] = 1'b0;
            end else if (!r_req[p] && $urandom_range(0, 2) == 0) begin
               set_req(p, 1'($urandom_range(0, 1)), {26'd0, 4'($urandom_range(0, 15)), 2'b00},
                       $urandom, 4'($urandom_range(0, 15)), 0);
            end
         end
      end
   endtask

   task automatic cycle();
      @(negedge clock_i);
      eval_cycle();
      @(posedge clock_i);
      #1;
      mem_respond();
      update_requesters();
   endtask

   initial begin
      reset_ni = 1'b0;
      mem_rdata_i = 32'd0;
      pend = 0; rnd_mode = 1'b0; m_active = 1'b0; m_rr = 1'b0;
      for (int p = 0; p < 2; p++) begin
         r_req[p] = 1'b0; r_we[p] = 1'b0; r_addr[p] = 32'd0;
         r_wdata[p] = 32'd0; r_be[p] = 4'd0; hold_cnt[p] = 0; granted[p] = 1'b0;
      end
      mem[32'h10] = 32'hDEADBEEF;
      shadow[32'h10] = 32'hDEADBEEF;
      repeat (3) cycle();
      reset_ni = 1'b1;

      // Contention straight out of reset: port 0 first, then strict alternation.
      set_req(0, 1'b0, 32'h40, 32'd0, 4'hF, 1);
      set_req(1, 1'b1, 32'h80, 32'hA5A50000, 4'hF, 1);
      repeat (22) cycle();

      set_req(0, 1'b0, 32'h10, 32'd0, 4'hF, 0);
      repeat (6) cycle();
      set_req(1, 1'b1, 32'h20, 32'h12345678, 4'hF, 0);
      repeat (6) cycle();
      set_req(0, 1'b0, 32'h20, 32'd0, 4'hF, 0);
      repeat (6) cycle();

      // Same port holding its request for three reads.
      set_req(0, 1'b0, 32'h10, 32'd0, 4'hF, 2);
      repeat (17) cycle();

      // Port 1 asks for a single busy cycle, then withdraws.
      set_req(0, 1'b0, 32'h14, 32'd0, 4'hF, 0);
      repeat (2) cycle();
      set_req(1, 1'b1, 32'h30, 32'hFFFF0000, 4'hF, 0);
      cycle();
      r_req[1] = 1'b0;
      repeat (8) cycle();

      rnd_mode = 1'b1;
      repeat (3000) cycle();

      // Reset in the middle of an access, then contention to confirm the pointer reset.
      rnd_mode = 1'b0;
      r_req[0] = 1'b0; r_req[1] = 1'b0;
      repeat (8) cycle();
      set_req(0, 1'b0, 32'h18, 32'd0, 4'hF, 0);
      repeat (2) cycle();
      reset_ni = 1'b0;
      repeat (3) cycle();
      reset_ni = 1'b1;
      set_req(0, 1'b0, 32'h1C, 32'd0, 4'hF, 0);
      set_req(1, 1'b0, 32'h24, 32'd0, 4'hF, 0);
      repeat (12) cycle();

      rnd_mode = 1'b1;
      repeat (500) cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
